// File: rtl/ex_hilo_unit.sv
// HI/LO execute unit: MOVZ/MOVN, MFHI/MFLO, MTHI/MTLO with forwarding, plus
// optional two-cycle multiply-accumulate (MADD/MADDU/MSUB/MSUBU) when HILO_MACC_EN is defined.
module ex_hilo_unit #(
   parameter int DW  = 32,
   parameter int OPW = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           valid_i,
   input  logic [OPW-1:0] op_i,
   input  logic [DW-1:0]  reg1_i,
   input  logic [DW-1:0]  reg2_i,
   input  logic           flush_i,
   input  logic           mem_whilo_i,
   input  logic [DW-1:0]  mem_hi_i,
   input  logic [DW-1:0]  mem_lo_i,
   input  logic           wb_whilo_i,
   input  logic [DW-1:0]  wb_hi_i,
   input  logic [DW-1:0]  wb_lo_i,
   output logic           wreg_o,
   output logic [DW-1:0]  wdata_o,
   output logic           whilo_o,
   output logic [DW-1:0]  hi_o,
   output logic [DW-1:0]  lo_o,
   output logic           stall_o
);

   localparam logic [OPW-1:0] OP_MOVZ  = OPW'(1);
   localparam logic [OPW-1:0] OP_MOVN  = OPW'(2);
   localparam logic [OPW-1:0] OP_MFHI  = OPW'(3);
   localparam logic [OPW-1:0] OP_MFLO  = OPW'(4);
   localparam logic [OPW-1:0] OP_MTHI  = OPW'(5);
   localparam logic [OPW-1:0] OP_MTLO  = OPW'(6);
   localparam logic [OPW-1:0] OP_MADD  = OPW'(7);
   localparam logic [OPW-1:0] OP_MADDU = OPW'(8);
   localparam logic [OPW-1:0] OP_MSUB  = OPW'(9);
   localparam logic [OPW-1:0] OP_MSUBU = OPW'(10);

   logic [DW-1:0]   r_hi;
   logic [DW-1:0]   r_lo;
   logic [DW-1:0]   w_hi_eff;
   logic [DW-1:0]   w_lo_eff;
   logic            w_in_acc;
   logic            w_start;
   logic [2*DW-1:0] w_acc_sum;

   // Newest value wins: memory stage, then writeback, then the architectural registers.
   assign w_hi_eff = mem_whilo_i ? mem_hi_i : (wb_whilo_i ? wb_hi_i : r_hi);
   assign w_lo_eff = mem_whilo_i ? mem_lo_i : (wb_whilo_i ? wb_lo_i : r_lo);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hi <= '0;
         r_lo <= '0;
      end else if (wb_whilo_i) begin
         r_hi <= wb_hi_i;
         r_lo <= wb_lo_i;
      end
   end

`ifdef HILO_MACC_EN
   typedef enum logic {S_IDLE, S_ACC} state_t;

   state_t          r_state;
   logic [2*DW-1:0] r_prod;
   logic            r_sub;
   logic            w_is_macc;
   logic            w_is_signed;
   logic [2*DW-1:0] w_a_ext;
   logic [2*DW-1:0] w_b_ext;
   logic [2*DW-1:0] w_prod;
   logic [2*DW-1:0] w_hilo_eff;

   assign w_is_macc   = (op_i == OP_MADD) || (op_i == OP_MADDU) ||
                        (op_i == OP_MSUB) || (op_i == OP_MSUBU);
   assign w_is_signed = (op_i == OP_MADD) || (op_i == OP_MSUB);
   // Product mod 2^(2*DW) of the extended operands equals the true signed/unsigned product.
   assign w_a_ext = w_is_signed ? {{DW{reg1_i[DW-1]}}, reg1_i} : {{DW{1'b0}}, reg1_i};
   assign w_b_ext = w_is_signed ? {{DW{reg2_i[DW-1]}}, reg2_i} : {{DW{1'b0}}, reg2_i};
   assign w_prod  = w_a_ext * w_b_ext;

   assign w_in_acc   = (r_state == S_ACC);
   assign w_start    = (r_state == S_IDLE) && valid_i && w_is_macc;
   assign w_hilo_eff = {w_hi_eff, w_lo_eff};
   assign w_acc_sum  = r_sub ? (w_hilo_eff - r_prod) : (w_hilo_eff + r_prod);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_prod  <= '0;
         r_sub   <= 1'b0;
      end else if (flush_i) begin
         r_state <= S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: if (w_start) begin
               r_prod  <= w_prod;
               r_sub   <= (op_i == OP_MSUB) || (op_i == OP_MSUBU);
               r_state <= S_ACC;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
`else
   assign w_in_acc  = 1'b0;
   assign w_start   = 1'b0;
   assign w_acc_sum = '0;
`endif

   always_comb begin
      wreg_o  = 1'b0;
      wdata_o = '0;
      whilo_o = 1'b0;
      hi_o    = '0;
      lo_o    = '0;
      stall_o = 1'b0;
      if (rst || flush_i) begin
         // everything stays zero
      end else if (w_in_acc) begin
         whilo_o      = 1'b1;
         {hi_o, lo_o} = w_acc_sum;
      end else if (valid_i) begin
         stall_o = w_start;
         case (op_i)
            OP_MOVZ: if (reg2_i == '0) begin
               wreg_o  = 1'b1;
               wdata_o = reg1_i;
            end
            OP_MOVN: if (reg2_i != '0) begin
               wreg_o  = 1'b1;
               wdata_o = reg1_i;
            end
            OP_MFHI: begin
               wreg_o  = 1'b1;
               wdata_o = w_hi_eff;
            end
            OP_MFLO: begin
               wreg_o  = 1'b1;
               wdata_o = w_lo_eff;
            end
            OP_MTHI: begin
               whilo_o = 1'b1;
               hi_o    = reg1_i;
               lo_o    = w_lo_eff;
            end
            OP_MTLO: begin
               whilo_o = 1'b1;
               hi_o    = w_hi_eff;
               lo_o    = reg1_i;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ex_hilo_unit.sv
// Directed self-checking bench for ex_hilo_unit; accumulate cases run when HILO_MACC_EN is defined.
module tb_ex_hilo_unit;
   localparam int DW = 32;
   localparam int OPW = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic           valid_i;
   logic [OPW-1:0] op_i;
   logic [DW-1:0]  reg1_i, reg2_i;
   logic           flush_i;
   logic           mem_whilo_i;
   logic [DW-1:0]  mem_hi_i, mem_lo_i;
   logic           wb_whilo_i;
   logic [DW-1:0]  wb_hi_i, wb_lo_i;
   logic           wreg_o, whilo_o, stall_o;
   logic [DW-1:0]  wdata_o, hi_o, lo_o;

   int n_pass = 0;
   int n_total = 0;

   ex_hilo_unit #(.DW(DW), .OPW(OPW)) dut (
      .clk(clk), .rst(rst), .valid_i(valid_i), .op_i(op_i),
      .reg1_i(reg1_i), .reg2_i(reg2_i), .flush_i(flush_i),
      .mem_whilo_i(mem_whilo_i), .mem_hi_i(mem_hi_i), .mem_lo_i(mem_lo_i),
      .wb_whilo_i(wb_whilo_i), .wb_hi_i(wb_hi_i), .wb_lo_i(wb_lo_i),
      .wreg_o(wreg_o), .wdata_o(wdata_o), .whilo_o(whilo_o),
      .hi_o(hi_o), .lo_o(lo_o), .stall_o(stall_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      $display("check %-14s observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [OPW-1:0] op,
                        input logic [DW-1:0] r1, input logic [DW-1:0] r2);
      valid_i = v; op_i = op; reg1_i = r1; reg2_i = r2;
      #1;
   endtask

   task automatic commit(input logic [DW-1:0] h, input logic [DW-1:0] l);
      wb_whilo_i = 1'b1; wb_hi_i = h; wb_lo_i = l;
      tick();
      wb_whilo_i = 1'b0; wb_hi_i = '0; wb_lo_i = '0;
      #1;
   endtask

   initial begin
      rst = 1'b1; flush_i = 1'b0;
      mem_whilo_i = 1'b0; mem_hi_i = '0; mem_lo_i = '0;
      wb_whilo_i = 1'b0; wb_hi_i = '0; wb_lo_i = '0;
      drive(1'b1, 4'd1, 32'h1234_5678, 32'h0);
      tick(); tick();
      chk("rst_wreg", {63'd0, wreg_o}, 64'd0);
      chk("rst_wdata", {32'd0, wdata_o}, 64'd0);
      chk("rst_stall", {63'd0, stall_o}, 64'd0);
      rst = 1'b0; #1;

      chk("movz_wreg", {63'd0, wreg_o}, 64'd1);
      chk("movz_wdata", {32'd0, wdata_o}, 64'h1234_5678);
      drive(1'b1, 4'd2, 32'h1234_5678, 32'h0);
      chk("movn_wreg", {63'd0, wreg_o}, 64'd0);
      chk("movn_wdata", {32'd0, wdata_o}, 64'd0);
      drive(1'b1, 4'd2, 32'h1234_5678, 32'h5);
      chk("movn_nz_wdata", {32'd0, wdata_o}, 64'h1234_5678);
      drive(1'b1, 4'd3, 32'h0, 32'h0);
      chk("mfhi_reset", {31'd0, wreg_o, wdata_o}, 64'h1_0000_0000);

      commit(32'h1, 32'h5);
      chk("mfhi_reg", {31'd0, wreg_o, wdata_o}, 64'h1_0000_0001);
      chk("mfhi_whilo", {63'd0, whilo_o}, 64'd0);
      mem_whilo_i = 1'b1; mem_hi_i = 32'hAA; mem_lo_i = 32'hCC;
      wb_whilo_i = 1'b1; wb_hi_i = 32'hBB; wb_lo_i = 32'hDD; #1;
      chk("fwd_mem_hi", {32'd0, wdata_o}, 64'hAA);
      mem_whilo_i = 1'b0; #1;
      chk("fwd_wb_hi", {32'd0, wdata_o}, 64'hBB);
      drive(1'b1, 4'd4, 32'h0, 32'h0);
      chk("fwd_wb_lo", {32'd0, wdata_o}, 64'hDD);
      wb_whilo_i = 1'b0; #1;
      chk("mflo_reg", {32'd0, wdata_o}, 64'h5);

      drive(1'b1, 4'd5, 32'hDEAD, 32'h0);
      chk("mthi_whilo", {62'd0, whilo_o, wreg_o}, 64'b10);
      chk("mthi_hilo", {hi_o, lo_o}, 64'h0000_DEAD_0000_0005);
      drive(1'b1, 4'd6, 32'hBEEF, 32'h0);
      chk("mtlo_hilo", {hi_o, lo_o}, 64'h0000_0001_0000_BEEF);

      drive(1'b0, 4'd3, 32'h0, 32'h0);
      chk("invalid", {61'd0, wreg_o, whilo_o, stall_o}, 64'd0);
      drive(1'b1, 4'd0, 32'h0, 32'h0);
      chk("nop", {61'd0, wreg_o, whilo_o, stall_o}, 64'd0);
      drive(1'b1, 4'd13, 32'h0, 32'h0);
      chk("op13_nop", {29'd0, wreg_o, wdata_o, whilo_o, stall_o}, 64'd0);
      drive(1'b1, 4'd3, 32'h0, 32'h0);
      flush_i = 1'b1; #1;
      chk("flush_mfhi", {63'd0, wreg_o}, 64'd0);
      wb_whilo_i = 1'b1; wb_hi_i = 32'h33; wb_lo_i = 32'h44;
      tick();
      flush_i = 1'b0; wb_whilo_i = 1'b0; #1;
      chk("flush_commit", {32'd0, wdata_o}, 64'h33);

`ifdef HILO_MACC_EN
      commit(32'h0, 32'h1);
      drive(1'b1, 4'd7, 32'hFFFF_FFFF, 32'h2);
      chk("madd_stall", {62'd0, stall_o, whilo_o}, 64'b10);
      tick();
      chk("madd_acc_ctl", {61'd0, stall_o, whilo_o, wreg_o}, 64'b010);
      chk("madd_sum", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFF);
      drive(1'b0, 4'd0, 32'h0, 32'h0);
      tick();
      chk("madd_idle", {62'd0, stall_o, whilo_o}, 64'd0);

      drive(1'b1, 4'd8, 32'hFFFF_FFFF, 32'h2);
      tick();
      chk("maddu_sum", {hi_o, lo_o}, 64'h0000_0001_FFFF_FFFF);
      drive(1'b0, 4'd0, 32'h0, 32'h0);
      tick();

      commit(32'h0, 32'h0);
      drive(1'b1, 4'd10, 32'h1, 32'h1);
      chk("msubu_stall", {63'd0, stall_o}, 64'd1);
      tick();
      chk("msubu_sum", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFF);
      drive(1'b0, 4'd0, 32'h0, 32'h0);
      tick();

      drive(1'b1, 4'd7, 32'h3, 32'h4);
      tick();
      mem_whilo_i = 1'b1; mem_hi_i = 32'h0; mem_lo_i = 32'hA; #1;
      chk("madd_fwd_sum", {hi_o, lo_o}, 64'h16);
      mem_whilo_i = 1'b0; mem_lo_i = '0;
      drive(1'b0, 4'd0, 32'h0, 32'h0);
      tick();

      drive(1'b1, 4'd9, 32'h2, 32'h3);
      tick();
      flush_i = 1'b1; #1;
      chk("acc_flush", {62'd0, whilo_o, stall_o}, 64'd0);
      drive(1'b0, 4'd0, 32'h0, 32'h0);
      tick();
      flush_i = 1'b0; #1;
      chk("flush_idle", {63'd0, whilo_o}, 64'd0);

      commit(32'h7, 32'h9);
      drive(1'b1, 4'd7, 32'h2, 32'h3);
      tick();
      rst = 1'b1; wb_whilo_i = 1'b1; wb_hi_i = 32'h55; wb_lo_i = 32'h66; #1;
      chk("acc_rst_out", {hi_o, lo_o}, 64'd0);
      chk("acc_rst_ctl", {61'd0, whilo_o, wreg_o, stall_o}, 64'd0);
      tick();
      rst = 1'b0; wb_whilo_i = 1'b0;
      drive(1'b0, 4'd0, 32'h0, 32'h0);
      chk("rst_idle", {63'd0, whilo_o}, 64'd0);
      drive(1'b1, 4'd5, 32'h0, 32'h0);
      chk("rst_lo_zero", {32'd0, lo_o}, 64'd0);
      drive(1'b1, 4'd3, 32'h0, 32'h0);
      chk("rst_hi_zero", {32'd0, wdata_o}, 64'd0);
`else
      drive(1'b1, 4'd7, 32'hFFFF_FFFF, 32'h2);
      chk("madd_off", {61'd0, stall_o, whilo_o, wreg_o}, 64'd0);
      tick();
      chk("madd_off_next", {62'd0, stall_o, whilo_o}, 64'd0);
      drive(1'b1, 4'd10, 32'h1, 32'h1);
      chk("msubu_off", {hi_o, lo_o}, 64'd0);
      rst = 1'b1; drive(1'b1, 4'd5, 32'hDEAD, 32'h0);
      chk("rst_mthi", {63'd0, whilo_o}, 64'd0);
      tick();
      rst = 1'b0;
      drive(1'b1, 4'd3, 32'h0, 32'h0);
      chk("rst_hi_zero", {32'd0, wdata_o}, 64'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
